// File: rtl/huffman_dcdec.sv
// Serial JPEG DC Huffman decoder: matches the luma/chroma category prefix, collects
// the magnitude bits and presents the sign-extended DC coefficient with a handshake.
module huffman_dcdec (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       is_luminance,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic       dc_valid,
  input  logic       dc_ready,
  output logic [9:0] dc_value,
  output logic [3:0] dc_size,
  output logic       dc_err
);

  localparam logic [1:0] S_CODE = 2'd0;
  localparam logic [1:0] S_MAG  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0] state;
  logic [4:0] pfx;
  logic [2:0] plen;
  logic       luma_q;
  logic [3:0] cnt;
  logic [3:0] size_q;
  logic [6:0] mag;

  logic       accept;
  logic       tbl;
  logic [5:0] code_w;
  logic [2:0] len_w;
  logic [7:0] mag_w;
  logic [5:0] m;

  // Result is {hit, err, cat}; neither hit nor err means more prefix bits are needed.
  function automatic logic [5:0] match(input logic luma, input logic [5:0] code,
                                       input logic [2:0] len);
    logic [5:0] r;
    r = 6'b0;
    if (luma) begin
      case (len)
        3'd3: case (code[2:0])
                3'b110: r = {2'b10, 4'd0};
                3'b101: r = {2'b10, 4'd1};
                3'b011: r = {2'b10, 4'd2};
                3'b010: r = {2'b10, 4'd3};
                3'b000: r = {2'b10, 4'd4};
                3'b001: r = {2'b10, 4'd5};
                3'b100: r = {2'b10, 4'd6};
                default: r = 6'b0;
              endcase
        3'd4: if (code[3:0] == 4'b1110) r = {2'b10, 4'd7};
        3'd5: if (code[4:0] == 5'b11110) r = {2'b10, 4'd8};
              else if (code[4:0] == 5'b11111) r = {2'b01, 4'd0};
        default: r = 6'b0;
      endcase
    end else begin
      case (len)
        3'd2: if (code[1:0] == 2'b01) r = {2'b10, 4'd0};
              else if (code[1:0] == 2'b00) r = {2'b10, 4'd1};
        3'd3: if (code[2:0] == 3'b100) r = {2'b10, 4'd2};
              else if (code[2:0] == 3'b101) r = {2'b10, 4'd3};
        3'd4: if (code[3:0] == 4'b1100) r = {2'b10, 4'd4};
              else if (code[3:0] == 4'b1101) r = {2'b10, 4'd5};
              else if (code[3:0] == 4'b1110) r = {2'b10, 4'd6};
        3'd5: if (code[4:0] == 5'b11110) r = {2'b10, 4'd7};
        3'd6: if (code == 6'b111110) r = {2'b10, 4'd8};
              else if (code == 6'b111111) r = {2'b01, 4'd0};
        default: r = 6'b0;
      endcase
    end
    return r;
  endfunction

  // A leading zero marks a negative value, stored offset by 2^n-1.
  function automatic logic signed [9:0] extend(input logic [7:0] v, input logic [3:0] n);
    logic [9:0] vz;
    logic [9:0] full;
    logic [2:0] msb;
    vz   = {2'b00, v};
    full = (10'd1 << n) - 10'd1;
    msb  = 3'(n - 4'd1);
    if (v[msb]) return $signed(vz);
    else        return $signed(vz - full);
  endfunction

  assign bit_ready = (state != S_HOLD) && !flush;
  assign accept    = bit_valid && bit_ready;
  assign code_w    = {pfx, bit_in};
  assign len_w     = plen + 3'd1;
  assign tbl       = (plen == 3'd0) ? is_luminance : luma_q;
  assign m         = match(tbl, code_w, len_w);
  assign mag_w     = {mag, bit_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CODE;
      pfx      <= '0;
      plen     <= '0;
      luma_q   <= 1'b0;
      cnt      <= '0;
      size_q   <= '0;
      mag      <= '0;
      dc_valid <= 1'b0;
      dc_value <= '0;
      dc_size  <= '0;
      dc_err   <= 1'b0;
    end else if (flush) begin
      state    <= S_CODE;
      pfx      <= '0;
      plen     <= '0;
      cnt      <= '0;
      dc_valid <= 1'b0;
    end else begin
      case (state)
        S_CODE: if (accept) begin
          if (plen == 3'd0) luma_q <= is_luminance;
          if (m[5] || m[4]) begin
            pfx  <= '0;
            plen <= '0;
            if (m[4] || m[3:0] == 4'd0) begin
              state    <= S_HOLD;
              dc_valid <= 1'b1;
              dc_err   <= m[4];
              dc_value <= '0;
              dc_size  <= '0;
            end else begin
              state  <= S_MAG;
              cnt    <= m[3:0];
              size_q <= m[3:0];
              mag    <= '0;
            end
          end else begin
            pfx  <= code_w[4:0];
            plen <= len_w;
          end
        end
        S_MAG: if (accept) begin
          mag <= mag_w[6:0];
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= S_HOLD;
            dc_valid <= 1'b1;
            dc_err   <= 1'b0;
            dc_size  <= size_q;
            dc_value <= $unsigned(extend(mag_w, size_q));
          end
        end
        S_HOLD: if (dc_ready) begin
          state    <= S_CODE;
          dc_valid <= 1'b0;
        end
        default: state <= S_CODE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_dcdec.sv
// Directed bench for huffman_dcdec: hand-decoded DC symbols, stalls, hold, flush, reset.
module tb_huffman_dcdec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       is_luminance = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic       dc_valid;
  logic       dc_ready = 1'b0;
  logic [9:0] dc_value;
  logic [3:0] dc_size;
  logic       dc_err;

  int checks = 0;
  int errors = 0;

  huffman_dcdec dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .is_luminance(is_luminance),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_value(dc_value),
    .dc_size(dc_size), .dc_err(dc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Send n bits MSB first; stall_max>0 inserts random idle cycles before each bit.
  task automatic send(input logic [15:0] bits, input int n, input logic luma,
                      input int stall_max);
    for (int i = n - 1; i >= 0; i--) begin
      int idle;
      idle = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      for (int k = 0; k < idle; k++) begin
        @(negedge clk);
        bit_valid = 1'b0;
      end
      @(negedge clk);
      is_luminance = luma;
      bit_in = bits[i];
      bit_valid = 1'b1;
      for (int k = 0; k < 20 && !bit_ready; k++) @(negedge clk);
      @(posedge clk);
      #1 bit_valid = 1'b0;
    end
  endtask

  task automatic expect_dc(input string tag, input integer val, input integer size,
                           input integer err);
    @(negedge clk);
    chk({tag, "_valid"}, dc_valid, 1);
    for (int k = 0; k < 10 && !dc_valid; k++) @(negedge clk);
    chk({tag, "_value"}, $signed(dc_value), val);
    chk({tag, "_size"}, dc_size, size);
    chk({tag, "_err"}, dc_err, err);
    dc_ready = 1'b1;
    @(posedge clk);
    #1 dc_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, dc_valid, 0);
  endtask

  initial begin
    #2;
    chk("rst_valid", dc_valid, 0);
    chk("rst_value", dc_value, 0);
    chk("rst_size", dc_size, 0);
    chk("rst_err", dc_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bit_ready, 1);

    send(16'b110, 3, 1'b1, 0);
    expect_dc("luma_cat0", 0, 0, 0);

    send(16'b010, 3, 1'b1, 0); send(16'b101, 3, 1'b1, 0);
    expect_dc("luma_p5", 5, 3, 0);

    send(16'b101, 3, 1'b0, 0); send(16'b010, 3, 1'b0, 0);
    expect_dc("chroma_m5", -5, 3, 0);

    send(16'b11110, 5, 1'b1, 0); send(16'b00000000, 8, 1'b1, 0);
    expect_dc("luma_m255", -255, 8, 0);

    send(16'b11110, 5, 1'b1, 0); send(16'b11111111, 8, 1'b1, 0);
    expect_dc("luma_p255", 255, 8, 0);

    send(16'b111111, 6, 1'b0, 0);
    expect_dc("chroma_err", 0, 0, 1);
    send(16'b00, 2, 1'b0, 0); send(16'b1, 1, 1'b0, 0);
    expect_dc("chroma_p1", 1, 1, 0);

    send(16'b11111, 5, 1'b1, 0);
    expect_dc("luma_err", 0, 0, 1);

    send(16'b01, 2, 1'b0, 0);
    expect_dc("chroma_cat0", 0, 0, 0);

    send(16'b000, 3, 1'b1, 0); send(16'b0111, 4, 1'b1, 0);
    expect_dc("luma_m8", -8, 4, 0);

    send(16'b1110, 4, 1'b1, 0); send(16'b1000000, 7, 1'b1, 0);
    expect_dc("luma_p64", 64, 7, 0);

    send(16'b011, 3, 1'b1, 0); send(16'b01, 2, 1'b1, 3);
    expect_dc("stall_m2", -2, 2, 0);
    send(16'b11110, 5, 1'b1, 0); send(16'b10110011, 8, 1'b1, 3);
    expect_dc("stall_p179", 179, 8, 0);

    // Table latched on first code bit: 101 as luma is cat1, magnitude 0 gives -1.
    send(16'b1, 1, 1'b1, 0); send(16'b01, 2, 1'b0, 0); send(16'b0, 1, 1'b0, 0);
    expect_dc("latch_tbl", -1, 1, 0);

    send(16'b010, 3, 1'b1, 0); send(16'b101, 3, 1'b1, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in = 1'b1;
      chk("hold_ready", bit_ready, 0);
      chk("hold_value", $signed(dc_value), 5);
      chk("hold_valid", dc_valid, 1);
    end
    bit_valid = 1'b0;
    expect_dc("hold_rel", 5, 3, 0);
    send(16'b110, 3, 1'b1, 0);
    expect_dc("after_hold", 0, 0, 0);

    send(16'b010, 3, 1'b1, 0); send(16'b10, 2, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", dc_valid, 0);
    chk("midrst_value", dc_value, 0);
    chk("midrst_size", dc_size, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_valid", dc_valid, 0);
    send(16'b101, 3, 1'b1, 0); send(16'b1, 1, 1'b1, 0);
    expect_dc("postrst_p1", 1, 1, 0);

    send(16'b010, 3, 1'b1, 0); send(16'b10, 2, 1'b1, 0);
    @(negedge clk);
    flush = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    #1 chk("flush_ready", bit_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    bit_valid = 1'b0;
    chk("flush_valid", dc_valid, 0);
    send(16'b101, 3, 1'b1, 0); send(16'b1, 1, 1'b1, 0);
    expect_dc("postflush_p1", 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
